// File: rtl/tcm_acc_pkg.sv
// Shared encodings for the TCM access controller: access sizes, FSM states,
// byte-mask constants and the latched-request record.
package tcm_acc_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC2 = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] MSK_B = 4'b0001;
  localparam logic [3:0] MSK_H = 4'b0011;
  localparam logic [3:0] MSK_W = 4'b1111;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } acc_req_t;

  // An access crosses into the next word only for a half at offset 3 or any
  // unaligned word.
  function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_W && off != 2'd0) || (size == SZ_H && off == 2'd3);
  endfunction

endpackage

// File: rtl/tcm_lane_align.sv
// Byte-lane alignment: store mask/data shifting into an 8-byte window and
// load lane extraction with sign/zero extension.
module tcm_lane_align
  import tcm_acc_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic        split,
  input  logic        hi,
  input  logic [31:0] wdata,
  input  logic [31:0] dout,
  input  logic [31:0] lo,
  output logic [3:0]  wem,
  output logic [31:0] wdat,
  output logic [31:0] rdata
);

  logic [3:0]  base;
  logic [7:0]  m8;
  logic [63:0] d64;
  logic [31:0] lane;

  always_comb begin
    case (size)
      SZ_B:    base = MSK_B;
      SZ_H:    base = MSK_H;
      SZ_W:    base = MSK_W;
      default: base = 4'b0000;
    endcase
    m8   = {4'b0000, base} << off;
    d64  = {32'h0, wdata} << {off, 3'b000};
    // hi selects the second (idx+1) half of the window for split accesses
    wem  = hi ? m8[7:4]    : m8[3:0];
    wdat = hi ? d64[63:32] : d64[31:0];
    lane = 32'((split ? {dout, lo} : {32'h0, dout}) >> {off, 3'b000});
    case (size)
      SZ_B:    rdata = uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    rdata = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: rdata = lane;
    endcase
  end

endmodule

// File: rtl/tcm_access_ctrl.sv
// LSU-side controller for the single-port TCM SRAM. Defining
// TCM_ACC_MISALIGN_SPLIT_EN splits word-crossing accesses into two SRAM cycles.
module tcm_access_ctrl #(
  parameter int AW     = 32,
  parameter int RAM_AW = 32,
  parameter int DP     = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  output logic [3:0]        ram_wem,
  input  logic [31:0]       ram_dout
);
  import tcm_acc_pkg::*;

  logic [1:0]        state;
  acc_req_t          req_r;
  logic              err_r;
  logic [RAM_AW-1:0] last_addr;

  logic [AW-3:0] idx;
  logic [1:0]    off;
  logic          accept, split_req, misalign, oor, req_err, hi;
  logic          l_split;
  logic [31:0]   l_lo, l_rdata, l_wdat;
  logic [3:0]    l_wem;
  acc_req_t      l_req;

  assign idx       = req_addr[AW-1:2];
  assign off       = req_addr[1:0];
  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign misalign  = (req_size == SZ_H && off[0]) || (req_size == SZ_W && off != 2'd0);

`ifdef TCM_ACC_MISALIGN_SPLIT_EN
  logic              split_r;
  logic [AW-3:0]     idx_r;
  logic [31:0]       lo_r;

  assign split_req = needs_split(req_size, off);
  assign hi        = (state == ST_ACC2);
  assign l_split   = split_r;
  assign l_lo      = lo_r;
  // A half at offset 1 stays inside one word, so with splitting nothing misaligns.
  assign req_err   = (req_size == SZ_ILL) || oor;
`else
  assign split_req = 1'b0;
  assign hi        = 1'b0;
  assign l_split   = 1'b0;
  assign l_lo      = 32'h0;
  assign req_err   = (req_size == SZ_ILL) || misalign || oor;
`endif

  assign oor = (64'(idx) >= 64'(DP)) || (split_req && (64'(idx) + 64'd1 >= 64'(DP)));

  assign l_req = (state == ST_IDLE)
               ? '{we: req_we, size: req_size, uns: req_unsigned, off: off, wdata: req_wdata}
               : req_r;

  tcm_lane_align u_align (
    .off   (l_req.off),
    .size  (l_req.size),
    .uns   (l_req.uns),
    .split (l_split),
    .hi    (hi),
    .wdata (l_req.wdata),
    .dout  (ram_dout),
    .lo    (l_lo),
    .wem   (l_wem),
    .wdat  (l_wdat),
    .rdata (l_rdata)
  );

  always_comb begin
    ram_addr = last_addr;
    ram_din  = l_wdat;
    ram_we   = 1'b0;
    ram_wem  = 4'b0000;
    case (state)
      ST_IDLE: begin
        ram_addr = RAM_AW'(idx);
        ram_we   = accept && req_we && !req_err;
        ram_wem  = ram_we ? l_wem : 4'b0000;
      end
`ifdef TCM_ACC_MISALIGN_SPLIT_EN
      ST_ACC2: begin
        ram_addr = RAM_AW'(idx_r + (AW-2)'(1));
        ram_we   = req_r.we && !rst;
        ram_wem  = ram_we ? l_wem : 4'b0000;
      end
`endif
      default: ;
    endcase
  end

  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid && err_r;
  // RAM address is frozen in RESP, so ram_dout and this stay stable under stall.
  assign resp_rdata = (resp_valid && !err_r && !req_r.we) ? l_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      err_r     <= 1'b0;
      req_r     <= '0;
      last_addr <= '0;
`ifdef TCM_ACC_MISALIGN_SPLIT_EN
      split_r   <= 1'b0;
      idx_r     <= '0;
      lo_r      <= 32'h0;
`endif
    end else begin
      if (state != ST_RESP) last_addr <= ram_addr;
      case (state)
        ST_IDLE: if (accept) begin
          err_r <= req_err;
          req_r <= l_req;
`ifdef TCM_ACC_MISALIGN_SPLIT_EN
          split_r <= split_req && !req_err;
          idx_r   <= idx;
`endif
          state <= (split_req && !req_err) ? ST_ACC2 : ST_RESP;
        end
`ifdef TCM_ACC_MISALIGN_SPLIT_EN
        ST_ACC2: begin
          lo_r  <= ram_dout;
          state <= ST_RESP;
        end
`endif
        ST_RESP: if (resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_access_ctrl.sv
// Bench for tcm_access_ctrl: SRAM model plus a byte-addressed reference memory.
module tb_tcm_access_ctrl;
  localparam int DP = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned, resp_valid, resp_ready, resp_err, req_ready;
  logic [31:0] req_addr, req_wdata, resp_rdata, ram_addr, ram_din, ram_dout;
  logic [1:0]  req_size;
  logic        ram_we;
  logic [3:0]  ram_wem;

  logic [31:0] mem    [0:DP-1];
  logic [7:0]  shadow [0:4*DP-1];
  int          wr_cnt = 0;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  tcm_access_ctrl #(.AW(32), .RAM_AW(32), .DP(DP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_wem(ram_wem), .ram_dout(ram_dout)
  );

  // SRAM: word index, 1-cycle read latency, dout held while not reading
  always @(posedge clk) begin
    if (ram_we) begin
      wr_cnt <= wr_cnt + 1;
      if (ram_addr < DP)
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr[8:0]][8*b +: 8] <= ram_din[8*b +: 8];
    end else begin
      ram_dout <= (ram_addr < DP) ? mem[ram_addr[8:0]] : 32'h0;
    end
  end

  task automatic preload(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int b = 0; b < 4; b++) shadow[4*w+b] = v[8*b +: 8];
  endtask

  // Reference: byte-granular memory, errors from the byte range touched
  function automatic void model(input logic [31:0] a, input logic we, input logic [1:0] sz,
                                input logic u, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er, output int lat);
    int n;
    longint first, last;
    logic [31:0] v;
    n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    first = longint'(a);
    last  = (first + n - 1) / 4;
    er    = (sz == 2'd3) || (last >= DP);
`ifndef TCM_ACC_MISALIGN_SPLIT_EN
    er = er || (first % n != 0);
`endif
    lat = (!er && (first / 4 != last)) ? 2 : 1;
    rd  = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) shadow[first+i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[first+i];
        if (!u && n == 1 && v[7])  v[31:8]  = '1;
        if (!u && n == 2 && v[15]) v[31:16] = '1;
        rd = v;
      end
    end
  endfunction

  // Caller is in the low clock phase; returns in the low phase of the cycle after handshake.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int wes, output logic [3:0] wem0, output logic [31:0] din0,
                        output logic rdy0);
    int w0;
    w0 = wr_cnt;
    req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    #1;
    rdy0 = req_ready; wem0 = ram_wem; din0 = ram_din;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin @(negedge clk); lat++; end
    rd = resp_rdata; er = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    wes = wr_cnt - w0;
  endtask

  logic [31:0] rd, din0, mrd;
  logic        er, rdy0, mer;
  logic [3:0]  wem0;
  int          lat, wes, mlat;

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'h0; req_we = 1'b1; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'hDEADBEEF; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); else n_pass++;
    n_chk++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got=%b exp=0", resp_err); else n_pass++;
    n_chk++; if (resp_rdata !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", resp_rdata); else n_pass++;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we got=%b exp=0", ram_we); else n_pass++;
    n_chk++; if (ram_wem !== 4'h0) $display("FAIL rst_ram_wem got=%b exp=0000", ram_wem); else n_pass++;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got=%b exp=0", req_ready); else n_pass++;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready got=%b exp=1", req_ready); else n_pass++;
  endtask

  task automatic test_load_ext;
    preload(5, 32'h8899AABB);
    do_req(32'h16, 1'b0, 2'd0, 1'b0, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (rd !== 32'hFFFFFF99 || lat != 1) $display("FAIL lb got=%h lat=%0d exp=ffffff99 lat=1", rd, lat); else n_pass++;
    do_req(32'h16, 1'b0, 2'd0, 1'b1, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (rd !== 32'h00000099) $display("FAIL lbu got=%h exp=00000099", rd); else n_pass++;
    do_req(32'h14, 1'b0, 2'd1, 1'b0, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (rd !== 32'hFFFFAABB) $display("FAIL lh got=%h exp=ffffaabb", rd); else n_pass++;
    do_req(32'h16, 1'b0, 2'd1, 1'b1, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (rd !== 32'h00008899) $display("FAIL lhu got=%h exp=00008899", rd); else n_pass++;
  endtask

  task automatic test_store_half;
    preload(2, 32'hCAFEF00D);
    do_req(32'h0A, 1'b1, 2'd1, 1'b0, 32'h00001234, rd, er, lat, wes, wem0, din0, rdy0);
    model(32'h0A, 1'b1, 2'd1, 1'b0, 32'h00001234, mrd, mer, mlat);
    n_chk++; if (wem0 !== 4'b1100) $display("FAIL sh_wem got=%b exp=1100", wem0); else n_pass++;
    n_chk++; if (din0 !== 32'h12340000) $display("FAIL sh_din got=%h exp=12340000", din0); else n_pass++;
    n_chk++; if (wes != 1 || rd !== 32'h0 || er !== 1'b0) $display("FAIL sh_resp wes=%0d rd=%h err=%b exp 1/0/0", wes, rd, er); else n_pass++;
    do_req(32'h08, 1'b0, 2'd2, 1'b0, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (rd !== 32'h1234F00D) $display("FAIL sh_readback got=%h exp=1234f00d", rd); else n_pass++;
  endtask

  task automatic test_stall;
    logic [31:0] r0;
    preload(6, 32'h13579BDF);
    req_valid = 1'b1; req_addr = 32'h18; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    r0 = resp_rdata;
    n_chk++; if (resp_valid !== 1'b1 || r0 !== 32'h13579BDF) $display("FAIL stall_first valid=%b rd=%h exp 1/13579bdf", resp_valid, r0); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h13579BDF || req_ready !== 1'b0)
        $display("FAIL stall_hold c=%0d valid=%b rd=%h ready=%b exp 1/13579bdf/0", c, resp_valid, resp_rdata, req_ready);
      else n_pass++;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_chk++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL stall_release valid=%b ready=%b exp 0/1", resp_valid, req_ready); else n_pass++;
  endtask

  task automatic test_misalign;
    preload(3, 32'h44332211);
    preload(4, 32'h88776655);
    do_req(32'h0D, 1'b0, 2'd2, 1'b0, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
`ifdef TCM_ACC_MISALIGN_SPLIT_EN
    n_chk++; if (rd !== 32'h55443322 || er !== 1'b0 || lat != 2) $display("FAIL lw_split rd=%h err=%b lat=%0d exp 55443322/0/2", rd, er, lat); else n_pass++;
`else
    n_chk++; if (rd !== 32'h0 || er !== 1'b1 || lat != 1) $display("FAIL lw_misalign rd=%h err=%b lat=%0d exp 0/1/1", rd, er, lat); else n_pass++;
    do_req(32'h0D, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (er !== 1'b1 || wes != 0 || mem[3] !== 32'h44332211) $display("FAIL sw_misalign err=%b wes=%0d w3=%h exp 1/0/44332211", er, wes, mem[3]); else n_pass++;
`endif
  endtask

  task automatic test_errors;
    logic [31:0] top;
    top = 32'(4 * DP);
    do_req(32'h10, 1'b0, 2'd3, 1'b0, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) $display("FAIL size11_ld err=%b rd=%h lat=%0d exp 1/0/1", er, rd, lat); else n_pass++;
    do_req(32'h10, 1'b1, 2'd3, 1'b0, 32'hA5A5A5A5, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (er !== 1'b1 || wes != 0) $display("FAIL size11_st err=%b writes=%0d exp 1/0", er, wes); else n_pass++;
    do_req(top, 1'b0, 2'd2, 1'b0, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL oor_ld err=%b rd=%h exp 1/0", er, rd); else n_pass++;
    do_req(top, 1'b1, 2'd2, 1'b0, 32'h5A5A5A5A, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (er !== 1'b1 || wes != 0) $display("FAIL oor_st err=%b writes=%0d exp 1/0", er, wes); else n_pass++;
  endtask

  task automatic test_back_to_back;
    preload(7, 32'h0BADC0DE);
    preload(8, 32'h600DF00D);
    do_req(32'h1C, 1'b0, 2'd2, 1'b0, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
    do_req(32'h20, 1'b0, 2'd2, 1'b0, 32'h0, rd, er, lat, wes, wem0, din0, rdy0);
    n_chk++; if (rdy0 !== 1'b1 || rd !== 32'h600DF00D || lat != 1) $display("FAIL b2b ready=%b rd=%h lat=%0d exp 1/600df00d/1", rdy0, rd, lat); else n_pass++;
  endtask

  task automatic test_reset_mid;
    preload(3, 32'h44332211);
    preload(4, 32'h88776655);
`ifdef TCM_ACC_MISALIGN_SPLIT_EN
    req_valid = 1'b1; req_addr = 32'h0D; req_we = 1'b1; req_size = 2'd2; req_wdata = 32'hDDCCBBAA;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    n_chk++; if (ram_we !== 1'b0) $display("FAIL rstmid_acc2_we got=%b exp=0", ram_we); else n_pass++;
    @(negedge clk);
    #1;
    n_chk++; if (resp_valid !== 1'b0 || ram_we !== 1'b0) $display("FAIL rstmid valid=%b we=%b exp 0/0", resp_valid, ram_we); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rstmid_idle ready=%b exp=1", req_ready); else n_pass++;
    n_chk++; if (mem[3] !== 32'hCCBBAA11 || mem[4] !== 32'h88776655) $display("FAIL rstmid_mem w3=%h w4=%h exp ccbbaa11/88776655", mem[3], mem[4]); else n_pass++;
    preload(3, 32'hCCBBAA11);
`else
    req_valid = 1'b1; req_addr = 32'h0C; req_we = 1'b0; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    n_chk++; if (resp_valid !== 1'b0 || ram_we !== 1'b0 || resp_rdata !== 32'h0) $display("FAIL rstmid valid=%b we=%b rd=%h exp 0/0/0", resp_valid, ram_we, resp_rdata); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rstmid_idle ready=%b exp=1", req_ready); else n_pass++;
`endif
  endtask

  task automatic test_random;
    logic [31:0] a, wd;
    logic [1:0]  sz;
    logic        we, u;
    int          w;
    for (int it = 0; it < 150; it++) begin
      w  = ($urandom_range(0, 3) == 0) ? DP - 2 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      a  = 32'(4 * w) + $urandom_range(0, 3);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      wd = $urandom;
      do_req(a, we, sz, u, wd, rd, er, lat, wes, wem0, din0, rdy0);
      model(a, we, sz, u, wd, mrd, mer, mlat);
      n_chk++;
      if (rd !== mrd || er !== mer || lat != mlat || rdy0 !== 1'b1 || wes != ((we && !mer) ? mlat : 0))
        $display("FAIL rand it=%0d a=%h we=%b sz=%0d rd=%h/%h err=%b/%b lat=%0d/%0d wr=%0d ready=%b",
                 it, a, we, sz, rd, mrd, er, mer, lat, mlat, wes, rdy0);
      else n_pass++;
    end
  endtask

  task automatic test_mem_image;
    for (int i = 0; i < DP; i++) begin
      n_chk++;
      if (mem[i] !== {shadow[4*i+3], shadow[4*i+2], shadow[4*i+1], shadow[4*i]})
        $display("FAIL mem_image w=%0d got=%h exp=%h", i, mem[i],
                 {shadow[4*i+3], shadow[4*i+2], shadow[4*i+1], shadow[4*i]});
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < DP; i++) preload(i, $urandom);
    ram_dout = 32'h0;
    test_reset();
    test_load_ext();
    test_store_half();
    test_stall();
    test_misalign();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    test_mem_image();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tcm_access_ctrl.md
# tcm_access_ctrl

Initiator-side controller for the single-port TCM SRAM model: accepts one load/store request at a time from the core's load/store unit and drives the SRAM port (addr, din, we, wem). The SRAM port takes a word index, has 1-cycle read latency and holds dout while we=0. The controller converts byte addresses to word indices, builds byte write masks, and extracts and sign-extends load data. It returns a single response per request over a valid/ready handshake. It sits between the LSU and an ITCM/DTCM instance.

## Interface
- AW, 32, byte address width of requests
- RAM_AW, 32, SRAM address (word index) width
- DP, 512, SRAM depth in words; word index ≥ DP is out of range
- clk  in  1  clock
- rst  in  1  reset; **synchronous, active-high** (fixed)
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_addr  in  AW  byte address
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend load data (LBU/LHU)
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal size, misaligned (see Configuration) or out-of-range
- ram_addr  out  RAM_AW  SRAM word index
- ram_din  out  32  SRAM write data
- ram_we  out  1  SRAM write enable (0 = read)
- ram_wem  out  4  SRAM byte write mask
- ram_dout  in  32  SRAM read data

## Operation
- States: IDLE, ACC2 (second half of a split access), RESP.
- req_ready = (state==IDLE) && !rst. Accept on req_valid && req_ready.
- Word index: idx = req_addr[AW-1:2]; off = req_addr[1:0].
- In IDLE, ram_addr = idx combinationally. ram_we=1 only on an accepted legal store.
- Store masks: byte 0001<<off, half 0011<<off, word 1111. ram_din = req_wdata<<(8*off), keeping the low 32 bits.
- Load data: lane = ram_dout>>(8*off); keep 8 or 16 bits; sign-extend unless req_unsigned. Word loads pass through unchanged.
- Errors (size 11, misaligned without split, idx or idx+1 ≥ DP):
  - ram_we=0 for the request.
  - Go to RESP with resp_err=1 and rdata=0.
- Aligned request: IDLE → RESP.
- Split request: IDLE → ACC2 → RESP.
- RESP:
  - Hold resp_valid until resp_ready.
  - ram_addr holds the last read index and ram_we=0, so ram_dout and resp_rdata stay stable.
  - On resp_ready, go to IDLE.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_err 0, resp_rdata 0, ram_we 0, ram_wem 0, req_ready 0 while rst=1.
- Aligned load or store accepted at cycle T → resp_valid at T+1. The store is written at the T clock edge.
- Split access accepted at T → second SRAM access at T+1 → resp_valid at T+2.
- Error accepted at T → resp_valid, resp_err at T+1.
- Back-to-back throughput: a new request can be accepted in the cycle after the resp handshake. Maximum rate is 1 request per 2 cycles.
- Reset mid-operation returns the controller to IDLE and drops any pending response. A split store interrupted after its first access leaves only the low part written.

## Configuration
- TCM_ACC_MISALIGN_SPLIT_EN defined: a misaligned half at off 3, or a misaligned word, is split into two SRAM accesses at idx and idx+1.
  - Loads: cycle 1 captures the low word into lo_r. Data = ({ram_dout, lo_r}>>(8*off))[31:0], then extended.
  - Stores: first access uses mask[3:0] and data[31:0] of the shifted 8-byte mask/data; the second uses bits [7:4] and [63:32].
- Not defined: any misaligned request returns resp_err=1 with no write. ACC2 and lo_r are absent.

## Structure
- Shared package tcm_acc_pkg: size encodings (SZ_B, SZ_H, SZ_W), state encodings, byte-mask constants.
- One combinational sub-module, tcm_lane_align: mask/data shifting for stores and lane extraction/extension for loads. The FSM, handshake and lo_r stay in the top level.

## Test plan
- Preload word 5 = 0x8899AABB; LB at addr 0x16 → rdata 0xFFFFFF99 at T+1; LBU → 0x00000099.
- SH wdata 0x1234 at addr 0x0A → ram_wem 1100, ram_din 0x12340000; read-back word 2 upper half = 0x1234.
- resp_ready held low for 3 cycles after LW → resp_valid and rdata stable, req_ready 0 throughout.
- LW at addr 0x0D, word 3 = 0x44332211, word 4 = 0x88776655:
  - with macro → rdata 0x55443322 at T+2;
  - without macro → resp_err=1 at T+1 and no RAM write.
- req_size 11, and LW at index DP (addr 4·DP) → resp_err=1, rdata 0, ram_we never 1.
- rst asserted during ACC2 of a split SW → next cycle state IDLE, resp_valid 0, ram_we 0; only the first word is modified.
